exe_alu_unit: RTL and testbench



---
 rtl/exe_alu_pkg.sv | 62 ++++++
 rtl/exe_alu_ctrl.sv | 58 +++++
 rtl/exe_alu_unit.sv | 111 +++++++++++
 tb/tb_exe_alu_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/exe_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exe_alu_pkg
// Description : Shared encodings for the execute-stage ALU: alu_op classes,
//               R-type funct codes and the decoded operation enum.
// Revision    : 1.0 - initial release
// ============================================================================
package exe_alu_pkg;

    localparam logic [3:0] c_ALUOP_RTYPE = 4'd0;
    localparam logic [3:0] c_ALUOP_ADD   = 4'd1;
    localparam logic [3:0] c_ALUOP_ADDU  = 4'd2;
    localparam logic [3:0] c_ALUOP_SUB   = 4'd3;
    localparam logic [3:0] c_ALUOP_AND   = 4'd4;
    localparam logic [3:0] c_ALUOP_OR    = 4'd5;
    localparam logic [3:0] c_ALUOP_XOR   = 4'd6;
    localparam logic [3:0] c_ALUOP_SLT   = 4'd7;
    localparam logic [3:0] c_ALUOP_SLTU  = 4'd8;
    localparam logic [3:0] c_ALUOP_LUI   = 4'd9;

    localparam logic [5:0] c_FUNCT_SLL  = 6'h00;
    localparam logic [5:0] c_FUNCT_SRL  = 6'h02;
    localparam logic [5:0] c_FUNCT_SRA  = 6'h03;
    localparam logic [5:0] c_FUNCT_SLLV = 6'h04;
    localparam logic [5:0] c_FUNCT_SRLV = 6'h06;
    localparam logic [5:0] c_FUNCT_SRAV = 6'h07;
    localparam logic [5:0] c_FUNCT_JR   = 6'h08;
    localparam logic [5:0] c_FUNCT_ADD  = 6'h20;
    localparam logic [5:0] c_FUNCT_ADDU = 6'h21;
    localparam logic [5:0] c_FUNCT_SUB  = 6'h22;
    localparam logic [5:0] c_FUNCT_SUBU = 6'h23;
    localparam logic [5:0] c_FUNCT_AND  = 6'h24;
    localparam logic [5:0] c_FUNCT_OR   = 6'h25;
    localparam logic [5:0] c_FUNCT_XOR  = 6'h26;
    localparam logic [5:0] c_FUNCT_NOR  = 6'h27;
    localparam logic [5:0] c_FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] c_FUNCT_SLTU = 6'h2B;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_ADDU = 5'd2,
        OP_SUB  = 5'd3,
        OP_SUBU = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_XOR  = 5'd7,
        OP_NOR  = 5'd8,
        OP_SLT  = 5'd9,
        OP_SLTU = 5'd10,
        OP_SLL  = 5'd11,
        OP_SRL  = 5'd12,
        OP_SRA  = 5'd13,
        OP_SLLV = 5'd14,
        OP_SRLV = 5'd15,
        OP_SRAV = 5'd16,
        OP_LUI  = 5'd17,
        OP_PASS = 5'd18
    } alu_op_e;

endpackage : exe_alu_pkg
`default_nettype wire

// File: rtl/exe_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exe_alu_ctrl
// Description : Combinational ALU-control decoder (alu_op + funct -> operation).
// Revision    : 1.0 - initial release
// ============================================================================
module exe_alu_ctrl
    import exe_alu_pkg::*;
(
    input  logic [3:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [4:0] o_operation
);

    alu_op_e w_op;

    always_comb begin
        w_op = OP_NOP;
        unique case (i_alu_op)
            c_ALUOP_RTYPE: begin
                case (i_funct)
                    c_FUNCT_ADD:  w_op = OP_ADD;
                    c_FUNCT_ADDU: w_op = OP_ADDU;
                    c_FUNCT_SUB:  w_op = OP_SUB;
                    c_FUNCT_SUBU: w_op = OP_SUBU;
                    c_FUNCT_AND:  w_op = OP_AND;
                    c_FUNCT_OR:   w_op = OP_OR;
                    c_FUNCT_XOR:  w_op = OP_XOR;
                    c_FUNCT_NOR:  w_op = OP_NOR;
                    c_FUNCT_SLT:  w_op = OP_SLT;
                    c_FUNCT_SLTU: w_op = OP_SLTU;
                    c_FUNCT_SLL:  w_op = OP_SLL;
                    c_FUNCT_SRL:  w_op = OP_SRL;
                    c_FUNCT_SRA:  w_op = OP_SRA;
                    c_FUNCT_SLLV: w_op = OP_SLLV;
                    c_FUNCT_SRLV: w_op = OP_SRLV;
                    c_FUNCT_SRAV: w_op = OP_SRAV;
                    c_FUNCT_JR:   w_op = OP_PASS;
                    default:      w_op = OP_NOP;
                endcase
            end
            c_ALUOP_ADD:  w_op = OP_ADD;
            c_ALUOP_ADDU: w_op = OP_ADDU;
            c_ALUOP_SUB:  w_op = OP_SUB;
            c_ALUOP_AND:  w_op = OP_AND;
            c_ALUOP_OR:   w_op = OP_OR;
            c_ALUOP_XOR:  w_op = OP_XOR;
            c_ALUOP_SLT:  w_op = OP_SLT;
            c_ALUOP_SLTU: w_op = OP_SLTU;
            c_ALUOP_LUI:  w_op = OP_LUI;
            default:      w_op = OP_NOP;
        endcase
    end

    assign o_operation = w_op;

endmodule : exe_alu_ctrl
`default_nettype wire

// File: rtl/exe_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : exe_alu_unit
// Description : Execute-stage ALU, branch-target adder and EXE/MEM output register.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_alu_unit
    import exe_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_hold,
    input  logic [3:0]      i_alu_op,
    input  logic [5:0]      i_funct,
    input  logic [4:0]      i_shamt,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [XLEN-1:0] i_pc_plus4,
    input  logic [XLEN-1:0] i_ext_imm,
    output logic [4:0]      o_operation,
    output logic [XLEN-1:0] o_alu_result,
    output logic            o_zero,
    output logic            o_overflow,
    output logic [XLEN-1:0] o_branch_addr
);

    logic [4:0]      w_operation;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic            w_add_ovf;
    logic            w_sub_ovf;
    logic [XLEN-1:0] w_result;
    logic            w_overflow;
    logic [XLEN-1:0] w_branch_addr;

    logic [XLEN-1:0] r_alu_result;
    logic            r_zero;
    logic            r_overflow;
    logic [XLEN-1:0] r_branch_addr;

    exe_alu_ctrl u_ctrl (
        .i_alu_op    (i_alu_op),
        .i_funct     (i_funct),
        .o_operation (w_operation)
    );

    assign w_sum  = i_op1 + i_op2;
    assign w_diff = i_op1 - i_op2;
    // Signed overflow: like-signed operands (op2 inverted for subtract) yield the other sign.
    assign w_add_ovf = (i_op1[XLEN-1] == i_op2[XLEN-1]) && (w_sum[XLEN-1]  != i_op1[XLEN-1]);
    assign w_sub_ovf = (i_op1[XLEN-1] != i_op2[XLEN-1]) && (w_diff[XLEN-1] != i_op1[XLEN-1]);

    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (w_operation)
            OP_ADD:  begin
                w_result   = w_sum;
                w_overflow = w_add_ovf;
            end
            OP_ADDU: w_result = w_sum;
            OP_SUB:  begin
                w_result   = w_diff;
                w_overflow = w_sub_ovf;
            end
            OP_SUBU: w_result = w_diff;
            OP_AND:  w_result = i_op1 & i_op2;
            OP_OR:   w_result = i_op1 | i_op2;
            OP_XOR:  w_result = i_op1 ^ i_op2;
            OP_NOR:  w_result = ~(i_op1 | i_op2);
            OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
            OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (i_op1 < i_op2)};
            OP_SLL:  w_result = i_op2 << i_shamt;
            OP_SRL:  w_result = i_op2 >> i_shamt;
            OP_SRA:  w_result = $unsigned($signed(i_op2) >>> i_shamt);
            OP_SLLV: w_result = i_op2 << i_op1[4:0];
            OP_SRLV: w_result = i_op2 >> i_op1[4:0];
            OP_SRAV: w_result = $unsigned($signed(i_op2) >>> i_op1[4:0]);
            OP_LUI:  w_result = {i_op2[15:0], 16'h0000};
            OP_PASS: w_result = i_op1;
            default: w_result = '0;
        endcase
    end

    // Shifting the full word drops ext_imm[31:30], matching {ext_imm[29:0], 2'b00}.
    assign w_branch_addr = i_pc_plus4 + (i_ext_imm << 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_result  <= '0;
            r_zero        <= 1'b0;
            r_overflow    <= 1'b0;
            r_branch_addr <= '0;
        end else if (!i_hold) begin
            r_alu_result  <= w_result;
            r_zero        <= (w_result == '0);
            r_overflow    <= w_overflow;
            r_branch_addr <= w_branch_addr;
        end
    end

    assign o_operation   = w_operation;
    assign o_alu_result  = r_alu_result;
    assign o_zero        = r_zero;
    assign o_overflow    = r_overflow;
    assign o_branch_addr = r_branch_addr;

endmodule : exe_alu_unit
`default_nettype wire

// File: tb/tb_exe_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_alu_unit
// Description : Directed self-checking bench for exe_alu_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_alu_unit;

    logic        clk;
    logic        rst_n;
    logic        i_hold;
    logic [3:0]  i_alu_op;
    logic [5:0]  i_funct;
    logic [4:0]  i_shamt;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic [31:0] i_pc_plus4;
    logic [31:0] i_ext_imm;
    logic [4:0]  o_operation;
    logic [31:0] o_alu_result;
    logic        o_zero;
    logic        o_overflow;
    logic [31:0] o_branch_addr;

    int r_tests;
    int r_fails;

    exe_alu_unit #(.XLEN(32)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_hold        (i_hold),
        .i_alu_op      (i_alu_op),
        .i_funct       (i_funct),
        .i_shamt       (i_shamt),
        .i_op1         (i_op1),
        .i_op2         (i_op2),
        .i_pc_plus4    (i_pc_plus4),
        .i_ext_imm     (i_ext_imm),
        .o_operation   (o_operation),
        .o_alu_result  (o_alu_result),
        .o_zero        (o_zero),
        .o_overflow    (o_overflow),
        .o_branch_addr (o_branch_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_tests++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] aop, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        i_alu_op = aop;
        i_funct  = fn;
        i_shamt  = sh;
        i_op1    = a;
        i_op2    = b;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic z,
                             input logic ov);
        check({tag, ".result"}, o_alu_result, res);
        check({tag, ".zero"}, {31'b0, o_zero}, {31'b0, z});
        check({tag, ".ovf"}, {31'b0, o_overflow}, {31'b0, ov});
    endtask

    initial begin
        r_tests    = 0;
        r_fails    = 0;
        rst_n      = 1'b0;
        i_hold     = 1'b0;
        i_pc_plus4 = 32'd0;
        i_ext_imm  = 32'd0;
        drive(4'd0, 6'h00, 5'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_out("rst", 32'd0, 1'b0, 1'b0);
        check("rst.branch", o_branch_addr, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd1, 6'h00, 5'd0, 32'd10, 32'd20);
        i_pc_plus4 = 32'd100;
        i_ext_imm  = 32'd1;
        #1;
        check("add.op", {27'b0, o_operation}, 32'd1);
        step();
        check_out("add", 32'd30, 1'b0, 1'b0);
        check("add.branch", o_branch_addr, 32'd104);

        // Asynchronous reset in the middle of a cycle clears outputs at once.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 32'd0, 1'b0, 1'b0);
        check("async_rst.branch", o_branch_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(4'd0, 6'h22, 5'd0, 32'd26, 32'd20);
        #1;
        check("rsub.op", {27'b0, o_operation}, 32'd3);
        step();
        check_out("rsub", 32'd6, 1'b0, 1'b0);
        drive(4'd0, 6'h22, 5'd0, 32'd20, 32'd20);
        step();
        check_out("rsub0", 32'd0, 1'b1, 1'b0);

        drive(4'd1, 6'h00, 5'd0, 32'h7FFF_FFFF, 32'd1);
        step();
        check_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
        drive(4'd2, 6'h00, 5'd0, 32'h7FFF_FFFF, 32'd1);
        step();
        check_out("addu", 32'h8000_0000, 1'b0, 1'b0);
        drive(4'd3, 6'h00, 5'd0, 32'h8000_0000, 32'd1);
        step();
        check_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);

        drive(4'd0, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        check_out("slt", 32'd1, 1'b0, 1'b0);
        drive(4'd0, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        check_out("sltu", 32'd0, 1'b1, 1'b0);
        drive(4'd0, 6'h03, 5'd4, 32'd0, 32'hF000_0000);
        step();
        check("sra", o_alu_result, 32'hFF00_0000);
        drive(4'd0, 6'h06, 5'd0, 32'h0000_0024, 32'hF000_0000);
        step();
        check("srlv", o_alu_result, 32'h0F00_0000);
        drive(4'd0, 6'h27, 5'd0, 32'h0F0F_0000, 32'h0000_00FF);
        step();
        check("nor", o_alu_result, 32'hF0F0_FF00);
        drive(4'd0, 6'h00, 5'd8, 32'd0, 32'h0000_0001);
        step();
        check("sll", o_alu_result, 32'h0000_0100);
        drive(4'd0, 6'h08, 5'd0, 32'hDEAD_BEEF, 32'd7);
        step();
        check("jr_pass", o_alu_result, 32'hDEAD_BEEF);

        i_pc_plus4 = 32'd504;
        i_ext_imm  = 32'hFFFF_FFFE;
        step();
        check("branch_neg", o_branch_addr, 32'd496);
        i_ext_imm = 32'd3;
        drive(4'd9, 6'h00, 5'd0, 32'd0, 32'h0000_1234);
        step();
        check("branch_pos", o_branch_addr, 32'd516);
        check_out("lui", 32'h1234_0000, 1'b0, 1'b0);

        i_hold = 1'b1;
        drive(4'd0, 6'h22, 5'd0, 32'd7, 32'd7);
        i_pc_plus4 = 32'd0;
        i_ext_imm  = 32'd0;
        repeat (2) step();
        check_out("hold", 32'h1234_0000, 1'b0, 1'b0);
        check("hold.branch", o_branch_addr, 32'd516);
        i_hold = 1'b0;

        drive(4'd0, 6'h3F, 5'd0, 32'd5, 32'd5);
        #1;
        check("unk_funct.op", {27'b0, o_operation}, 32'd0);
        step();
        check_out("unk_funct", 32'd0, 1'b1, 1'b0);
        drive(4'd12, 6'h20, 5'd0, 32'd5, 32'd5);
        #1;
        check("aop12.op", {27'b0, o_operation}, 32'd0);
        step();
        check_out("aop12", 32'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule : tb_exe_alu_unit
`default_nettype wire
